// File: rtl/ex_stage_md.sv
// Execute stage: XLEN ALU with operand forwarding, iterative RV-M mul/div unit and EX/MEM output register.
// Optional build macro EX_MUL_FAST_EN: single-cycle combinational multiplies; the FSM then only divides.
module ex_stage_md #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              out_ready_i,
    input  logic [1:0]        fwd_a_sel_i,
    input  logic [1:0]        fwd_b_sel_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic [XLEN-1:0]   mem_fwd_data_i,
    input  logic              alu_src_i,
    input  logic [3:0]        alu_ctl_i,
    input  logic              md_en_i,
    input  logic [2:0]        md_op_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              reg_write_i,
    output logic              out_valid_o,
    output logic [XLEN-1:0]   out_result_o,
    output logic [XLEN-1:0]   out_store_data_o,
    output logic [REG_AW-1:0] out_rd_o,
    output logic              out_reg_write_o,
    output logic              busy_o
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0]   op_a, fwd_b, op_b, alu_res, fast_res, md_res;
    logic [SHW-1:0]    shamt;
    logic              fast_mul, out_free, accept, md_start, alu_load;
    logic              a_sgn, b_sgn, a_neg, b_neg, res_neg, div_zero, div_ovf, md_special;
    logic [XLEN-1:0]   a_mag, b_mag;

    logic [XLEN-1:0]   hi_q, lo_q, m_q, sd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q, rw_q;
    logic [2:0]        op_q;
    logic [REG_AW-1:0] rd_q;

    logic              out_valid_q, out_rw_q;
    logic [XLEN-1:0]   out_res_q, out_sd_q;
    logic [REG_AW-1:0] out_rd_q;

    always_comb begin
        case (fwd_a_sel_i)
            2'b01:   op_a = wb_data_i;
            2'b10:   op_a = mem_fwd_data_i;
            default: op_a = rs1_data_i;
        endcase
        case (fwd_b_sel_i)
            2'b01:   fwd_b = wb_data_i;
            2'b10:   fwd_b = mem_fwd_data_i;
            default: fwd_b = rs2_data_i;
        endcase
    end

    assign op_b  = alu_src_i ? imm_i : fwd_b;
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_ctl_i)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b0111: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'b1001: alu_res = op_a ^ op_b;
            4'b1010: alu_res = op_a << shamt;
            4'b1011: alu_res = op_a >> shamt;
            4'b1100: alu_res = $signed(op_a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MUL_FAST_EN
    logic [2*XLEN-1:0] fm_a, fm_b, fm_p;
    always_comb begin
        fm_a = {{XLEN{(md_op_i == 3'b001 || md_op_i == 3'b010) & op_a[XLEN-1]}}, op_a};
        fm_b = {{XLEN{(md_op_i == 3'b001) & op_b[XLEN-1]}}, op_b};
        fm_p = fm_a * fm_b;
        fast_res = (md_op_i == 3'b000) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    end
    assign fast_mul = md_en_i & ~md_op_i[2];
`else
    assign fast_res = '0;
    assign fast_mul = 1'b0;
`endif

    // Signed ops run on magnitudes; the result sign is reapplied in DONE.
    always_comb begin
        a_sgn   = (md_op_i == 3'b001) || (md_op_i == 3'b010) || (md_op_i == 3'b100) || (md_op_i == 3'b110);
        b_sgn   = (md_op_i == 3'b001) || (md_op_i == 3'b100) || (md_op_i == 3'b110);
        a_neg   = a_sgn & op_a[XLEN-1];
        b_neg   = b_sgn & op_b[XLEN-1];
        a_mag   = a_neg ? -op_a : op_a;
        b_mag   = b_neg ? -op_b : op_b;
        res_neg = (md_op_i == 3'b110) ? a_neg : (a_neg ^ b_neg);
        div_zero   = (op_b == '0);
        div_ovf    = md_op_i[2] & ~md_op_i[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
        md_special = md_op_i[2] & (div_zero | div_ovf);
    end

    assign out_free   = ~out_valid_q | out_ready_i;
    assign in_ready_o = (state_q == S_IDLE) & out_free;
    assign accept     = in_valid_i & in_ready_o;
    assign md_start   = accept & md_en_i & ~fast_mul;
    assign alu_load   = accept & ~md_start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (md_start) state_d = md_special ? S_DONE : (md_op_i[2] ? S_DIV : S_MUL);
            S_MUL, S_DIV: if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
            S_DONE: if (out_free) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    logic [XLEN:0] mul_sum, div_r, div_sub;
    logic          div_ge;
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
        div_r   = {hi_q, lo_q[XLEN-1]};
        div_sub = div_r - {1'b0, m_q};
        div_ge  = (div_r >= {1'b0, m_q});
    end

    // Special divides preload the answer: quotient slot in lo_q, remainder slot in hi_q.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            sd_q  <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            rw_q  <= 1'b0;
            op_q  <= '0;
            rd_q  <= '0;
        end else if (state_q == S_IDLE && md_start) begin
            op_q  <= md_op_i;
            rd_q  <= rd_i;
            rw_q  <= reg_write_i;
            sd_q  <= fwd_b;
            cnt_q <= '0;
            if (md_special) begin
                hi_q  <= div_zero ? op_a : '0;
                lo_q  <= div_zero ? '1 : op_a;
                m_q   <= b_mag;
                neg_q <= 1'b0;
            end else begin
                hi_q  <= '0;
                lo_q  <= md_op_i[2] ? a_mag : b_mag;
                m_q   <= md_op_i[2] ? b_mag : a_mag;
                neg_q <= res_neg;
            end
        end else if (state_q == S_MUL) begin
            {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
            cnt_q        <= cnt_q + 1'b1;
        end else if (state_q == S_DIV) begin
            hi_q  <= div_ge ? div_sub[XLEN-1:0] : div_r[XLEN-1:0];
            lo_q  <= {lo_q[XLEN-2:0], div_ge};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   div_pick, div_c;
    always_comb begin
        prod_c   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        div_pick = op_q[1] ? hi_q : lo_q;
        div_c    = neg_q ? -div_pick : div_pick;
        if (op_q[2])             md_res = div_c;
        else if (op_q == 3'b000) md_res = prod_c[XLEN-1:0];
        else                     md_res = prod_c[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_sd_q    <= '0;
            out_rd_q    <= '0;
            out_rw_q    <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (alu_load) begin
            out_valid_q <= 1'b1;
            out_res_q   <= fast_mul ? fast_res : alu_res;
            out_sd_q    <= fwd_b;
            out_rd_q    <= rd_i;
            out_rw_q    <= reg_write_i;
        end else if (state_q == S_DONE && out_free) begin
            out_valid_q <= 1'b1;
            out_res_q   <= md_res;
            out_sd_q    <= sd_q;
            out_rd_q    <= rd_q;
            out_rw_q    <= rw_q;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_result_o     = out_res_q;
    assign out_store_data_o = out_sd_q;
    assign out_rd_o         = out_rd_q;
    assign out_reg_write_o  = out_valid_q & out_rw_q;
    assign busy_o           = (state_q != S_IDLE);
endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: directed corner cases, then randomized ops against an arithmetic reference model.
module tb_ex_stage_md;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk_i, rst_i, flush_i, in_valid_i, in_ready_o, out_ready_i;
    logic [1:0]        fwd_a_sel_i, fwd_b_sel_i;
    logic [XLEN-1:0]   rs1_data_i, rs2_data_i, imm_i, wb_data_i, mem_fwd_data_i;
    logic              alu_src_i, md_en_i, reg_write_i;
    logic [3:0]        alu_ctl_i;
    logic [2:0]        md_op_i;
    logic [REG_AW-1:0] rd_i;
    logic              out_valid_o, out_reg_write_o, busy_o;
    logic [XLEN-1:0]   out_result_o, out_store_data_o;
    logic [REG_AW-1:0] out_rd_o;

    ex_stage_md #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_ready_i(out_ready_i),
        .fwd_a_sel_i(fwd_a_sel_i), .fwd_b_sel_i(fwd_b_sel_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .wb_data_i(wb_data_i), .mem_fwd_data_i(mem_fwd_data_i),
        .alu_src_i(alu_src_i), .alu_ctl_i(alu_ctl_i), .md_en_i(md_en_i), .md_op_i(md_op_i),
        .rd_i(rd_i), .reg_write_i(reg_write_i),
        .out_valid_o(out_valid_o), .out_result_o(out_result_o), .out_store_data_o(out_store_data_o),
        .out_rd_o(out_rd_o), .out_reg_write_o(out_reg_write_o), .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v, wb, mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return reg_v;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a, b);
        int sh;
        longint sa, sb;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ctl)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return (a < b) ? 32'd1 : 32'd0;
            4'd9:  return a ^ b;
            4'd10: return 32'(longint'(a) * (longint'(1) << sh));
            4'd11: return a / (32'd1 << sh);
            4'd12: return 32'((sa < 0) ? -((-sa + (longint'(1) << sh) - 1) / (longint'(1) << sh)) : sa / (longint'(1) << sh));
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic mden, input logic [2:0] op, input logic [31:0] a, b);
        if (!mden) return 1;
`ifdef EX_MUL_FAST_EN
        if (op < 3'd4) return 1;
`endif
        if (op >= 3'd4 && b == 0) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_idle();
        in_valid_i = 0; flush_i = 0; fwd_a_sel_i = 0; fwd_b_sel_i = 0;
        rs1_data_i = 0; rs2_data_i = 0; imm_i = 0; wb_data_i = 0; mem_fwd_data_i = 0;
        alu_src_i = 0; alu_ctl_i = 0; md_en_i = 0; md_op_i = 0; rd_i = 0; reg_write_i = 0;
    endtask

    task automatic scramble();
        rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
        wb_data_i = $urandom; mem_fwd_data_i = $urandom;
        fwd_a_sel_i = 2'($urandom_range(0, 3)); fwd_b_sel_i = 2'($urandom_range(0, 3));
        alu_src_i = 1'($urandom_range(0, 1));
    endtask

    // Present one instruction and return right after (#1) the edge that accepts it.
    task automatic issue(input logic [3:0] ctl, input logic mden, input logic [2:0] mdop,
                         input logic [1:0] asel, bsel, input logic [31:0] rs1, rs2, imm, wb, mem,
                         input logic src, input logic [4:0] rd, input logic rw);
        int n;
        alu_ctl_i = ctl; md_en_i = mden; md_op_i = mdop; fwd_a_sel_i = asel; fwd_b_sel_i = bsel;
        rs1_data_i = rs1; rs2_data_i = rs2; imm_i = imm; wb_data_i = wb; mem_fwd_data_i = mem;
        alu_src_i = src; rd_i = rd; reg_write_i = rw; in_valid_i = 1;
        n = 0;
        while (!in_ready_o && n < 100) begin
            @(posedge clk_i); #1; n++;
        end
        if (n >= 100) check("in_ready_timeout", 64'(in_ready_o), 64'd1);
        @(posedge clk_i); #1;
        in_valid_i = 0;
        scramble();
    endtask

    task automatic run_op(input string tag, input logic [3:0] ctl, input logic mden, input logic [2:0] mdop,
                          input logic [1:0] asel, bsel, input logic [31:0] rs1, rs2, imm, wb, mem,
                          input logic src, input logic [4:0] rd, input logic rw,
                          input bit have_want, input logic [31:0] want);
        logic [31:0] a, bsrc, b, exp;
        int lat, stall, n;
        a    = pick(asel, rs1, wb, mem);
        bsrc = pick(bsel, rs2, wb, mem);
        b    = src ? imm : bsrc;
        exp  = have_want ? want : (mden ? ref_md(mdop, a, b) : ref_alu(ctl, a, b));
        exp_q.push_back(exp);
        lat  = exp_latency(mden, mdop, a, b);
        issue(ctl, mden, mdop, asel, bsel, rs1, rs2, imm, wb, mem, src, rd, rw);
        n = 1; stall = 0;
        while (!out_valid_o && n < 200) begin
            if (!in_ready_o) stall++;
            @(posedge clk_i); #1; n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_stall"}, 64'(stall), 64'(lat == 1 ? 0 : lat - 1));
        check({tag, "_result"}, 64'(out_result_o), 64'(exp_q.pop_front()));
        check({tag, "_store"}, 64'(out_store_data_o), 64'(bsrc));
        check({tag, "_rd"}, 64'(out_rd_o), 64'(rd));
        check({tag, "_rw"}, 64'(out_reg_write_o), 64'(rw));
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready_o), 64'd1);
    endtask

    task automatic do_reset();
        drive_idle();
        out_ready_i = 1;
        rst_i = 1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
        @(posedge clk_i); #1;
    endtask

    logic [3:0] ctl_tab [11] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd3};

    initial begin
        int cnt;
        logic [31:0] held;
        do_reset();
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_result", 64'(out_result_o), 64'd0);
        check("rst_store", 64'(out_store_data_o), 64'd0);
        check("rst_rd", 64'(out_rd_o), 64'd0);
        check("rst_rw", 64'(out_reg_write_o), 64'd0);

        run_op("add", 4'd2, 0, 3'd0, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 0, 5'd3, 1, 1, 32'd12);
        run_op("sub_fwd", 4'd6, 0, 3'd0, 2'b01, 2'b00, 32'd55, 32'd1, 32'd0, 32'd100, 32'd9, 0, 5'd4, 1, 1, 32'd99);
        run_op("sra_imm", 4'd12, 0, 3'd0, 2'b00, 2'b00, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 32'd0, 1, 5'd5, 1, 1, 32'hF800_0000);
        run_op("div", 4'd0, 1, 3'd4, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'd0, 0, 5'd6, 1, 1, 32'hFFFF_FFFD);
        run_op("rem", 4'd0, 1, 3'd6, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'd0, 0, 5'd7, 1, 1, 32'hFFFF_FFFF);
        run_op("divu_z", 4'd0, 1, 3'd5, 2'b00, 2'b00, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 0, 5'd8, 1, 1, 32'hFFFF_FFFF);
        run_op("remu_z", 4'd0, 1, 3'd7, 2'b00, 2'b00, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 0, 5'd9, 0, 1, 32'd10);
        run_op("div_ovf", 4'd0, 1, 3'd4, 2'b00, 2'b10, 32'h8000_0000, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 5'd10, 1, 1, 32'h8000_0000);
        run_op("rem_ovf", 4'd0, 1, 3'd6, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 0, 5'd11, 1, 1, 32'd0);
        run_op("mulhu", 4'd0, 1, 3'd3, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 0, 5'd12, 1, 1, 32'hFFFF_FFFE);
        run_op("mul", 4'd0, 1, 3'd0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 0, 5'd13, 1, 1, 32'd1);
        run_op("mulh", 4'd0, 1, 3'd1, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0, 0, 5'd14, 1, 1, 32'hFFFF_FFFF);

        // Flush during a divide: no result may ever appear.
        issue(4'd0, 1, 3'd4, 2'b00, 2'b00, 32'd1000, 32'd7, 32'd0, 32'd0, 32'd0, 0, 5'd1, 1);
        repeat (10) begin @(posedge clk_i); #1; end
        check("flush_busy_before", 64'(busy_o), 64'd1);
        flush_i = 1;
        @(posedge clk_i); #1;
        flush_i = 0;
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_in_ready", 64'(in_ready_o), 64'd1);
        cnt = 0;
        repeat (40) begin
            if (out_valid_o) cnt++;
            @(posedge clk_i); #1;
        end
        check("flush_no_valid", 64'(cnt), 64'd0);

        // Accept coinciding with flush is discarded.
        flush_i = 1;
        issue(4'd2, 0, 3'd0, 2'b00, 2'b00, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 0, 5'd2, 1);
        flush_i = 0;
        check("flush_accept_valid", 64'(out_valid_o), 64'd0);
        check("flush_accept_busy", 64'(busy_o), 64'd0);

        // Back-pressure: outputs hold and upstream stalls until out_ready returns.
        out_ready_i = 0;
        issue(4'd2, 0, 3'd0, 2'b00, 2'b00, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 0, 5'd17, 1);
        held = out_result_o;
        check("bp_first", 64'(held), 64'd7);
        repeat (5) begin
            @(posedge clk_i); #1;
            check("bp_valid", 64'(out_valid_o), 64'd1);
            check("bp_hold", 64'(out_result_o), 64'd7);
            check("bp_rd", 64'(out_rd_o), 64'd17);
            check("bp_in_ready", 64'(in_ready_o), 64'd0);
        end
        out_ready_i = 1;
        #1;
        check("bp_release_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk_i); #1;
        check("bp_drained", 64'(out_valid_o), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic mden;
            logic [2:0] op;
            mden = ($urandom_range(0, 9) < 4);
            op   = 3'($urandom_range(0, 7));
            run_op("rnd", ctl_tab[$urandom_range(0, 10)], mden, op,
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val(),
                   mden ? 1'b0 : 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, 32'd0);
        end

        // Asynchronous reset in the middle of a divide.
        issue(4'd0, 1, 3'd5, 2'b00, 2'b00, 32'd12345, 32'd11, 32'd0, 32'd0, 32'd0, 0, 5'd20, 1);
        repeat (5) begin @(posedge clk_i); #1; end
        #2 rst_i = 1;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_valid", 64'(out_valid_o), 64'd0);
        check("arst_in_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk_i);
        rst_i = 0;
        cnt = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (out_valid_o) cnt++;
        end
        check("arst_no_valid", 64'(cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
